// File: rtl/pwm_ramp_controller.sv
// pwm_ramp_controller
//   Counter-compare PWM whose applied duty ramps towards a requested target in
//   fixed steps. The applied duty only changes on the last clock of a PWM period,
//   so every output pulse is emitted whole.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        synchronous active-high reset
//   TGT_DUTY   requested target duty
//   TGT_VALID  TGT_DUTY valid
//   TGT_READY  a new target can be accepted (idle)
//   PWM_OUT    PWM waveform, high while period counter < applied duty
//   DUTY       currently applied duty
//   BUSY       ramp in progress
//   PERIOD_END high on the last clock of each PWM period
module pwm_ramp_controller #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned STEP     = 16,
  parameter int unsigned RAMP_DIV = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] TGT_DUTY,
  input  logic             TGT_VALID,
  output logic             TGT_READY,
  output logic             PWM_OUT,
  output logic [WIDTH-1:0] DUTY,
  output logic             BUSY,
  output logic             PERIOD_END
);

  localparam int unsigned     DivW    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(RAMP_DIV - 1);
  localparam logic [WIDTH-1:0] StepVal = WIDTH'(STEP);

  typedef enum logic [1:0] {StIdle, StRampUp, StRampDown} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  duty_q, duty_d;
  logic [WIDTH-1:0]  target_q, target_d;
  logic [DivW-1:0]   divcnt_q, divcnt_d;

  logic              period_end;
  logic [WIDTH-1:0]  up_gap;
  logic [WIDTH-1:0]  down_gap;

  assign period_end = (cnt_q == '1);
  // Gaps are only meaningful in their own ramp direction, where they cannot wrap.
  assign up_gap     = target_q - duty_q;
  assign down_gap   = duty_q - target_q;

  always_comb begin
    cnt_d    = cnt_q + 1'b1;
    duty_d   = duty_q;
    target_d = target_q;
    divcnt_d = divcnt_q;
    state_d  = state_q;

    case (state_q)
      StIdle: begin
        // Accept cycle never steps, even when it lands on a period boundary.
        if (TGT_VALID) begin
          target_d = TGT_DUTY;
          divcnt_d = '0;
          if (TGT_DUTY > duty_q) begin
            state_d = StRampUp;
          end else if (TGT_DUTY < duty_q) begin
            state_d = StRampDown;
          end
        end
      end

      StRampUp, StRampDown: begin
        if (period_end) begin
          if (divcnt_q == DivLast) begin
            divcnt_d = '0;
            if (state_q == StRampUp) begin
              if (up_gap <= StepVal) begin
                duty_d  = target_q;
                state_d = StIdle;
              end else begin
                duty_d = duty_q + StepVal;
              end
            end else begin
              if (down_gap <= StepVal) begin
                duty_d  = target_q;
                state_d = StIdle;
              end else begin
                duty_d = duty_q - StepVal;
              end
            end
          end else begin
            divcnt_d = divcnt_q + 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      duty_q   <= '0;
      target_q <= '0;
      divcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      divcnt_q <= divcnt_d;
    end
  end

  assign PERIOD_END = period_end;
  assign PWM_OUT    = (cnt_q < duty_q);
  assign DUTY       = duty_q;
  assign BUSY       = (state_q != StIdle);
  assign TGT_READY  = (state_q == StIdle);

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Directed bench for pwm_ramp_controller. Instance a uses STEP=16, RAMP_DIV=1;
// instance b uses STEP=16, RAMP_DIV=3. Both share clock and reset, so a single
// bench-side period counter (m_cnt) tracks both. Inputs change and outputs are
// sampled just after the falling edge.
module tb_pwm_ramp_controller;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;

  logic [7:0] a_tgt_duty = '0;
  logic       a_tgt_valid = 1'b0;
  logic       a_tgt_ready, a_pwm_out, a_busy, a_period_end;
  logic [7:0] a_duty;

  logic [7:0] b_tgt_duty = '0;
  logic       b_tgt_valid = 1'b0;
  logic       b_tgt_ready, b_pwm_out, b_busy, b_period_end;
  logic [7:0] b_duty;

  int checks   = 0;
  int failures = 0;
  logic [7:0] m_cnt = '0;

  always #5 CLK = ~CLK;

  pwm_ramp_controller #(.WIDTH(8), .STEP(16), .RAMP_DIV(1)) dut_a (
    .CLK        (CLK),
    .RST        (RST),
    .TGT_DUTY   (a_tgt_duty),
    .TGT_VALID  (a_tgt_valid),
    .TGT_READY  (a_tgt_ready),
    .PWM_OUT    (a_pwm_out),
    .DUTY       (a_duty),
    .BUSY       (a_busy),
    .PERIOD_END (a_period_end)
  );

  pwm_ramp_controller #(.WIDTH(8), .STEP(16), .RAMP_DIV(3)) dut_b (
    .CLK        (CLK),
    .RST        (RST),
    .TGT_DUTY   (b_tgt_duty),
    .TGT_VALID  (b_tgt_valid),
    .TGT_READY  (b_tgt_ready),
    .PWM_OUT    (b_pwm_out),
    .DUTY       (b_duty),
    .BUSY       (b_busy),
    .PERIOD_END (b_period_end)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: advance to the next falling edge and track the period counter.
  task automatic tick();
    @(negedge CLK);
    m_cnt = m_cnt + 8'd1;
  endtask

  // Advance until just after the next period-boundary edge (m_cnt back to 0).
  task automatic next_boundary();
    tick();
    while (m_cnt != 8'd0) tick();
  endtask

  int   highs;
  logic busy_seen;

  initial begin
    // Reset: one edge with RST high puts the counter at 0.
    @(negedge CLK);
    @(negedge CLK);
    m_cnt = '0;
    check("rst_duty", a_duty, 0);
    check("rst_ready", a_tgt_ready, 1);
    check("rst_busy", a_busy, 0);
    check("rst_pwm", a_pwm_out, 0);
    check("rst_period_end", a_period_end, 0);
    RST = 1'b0;

    // 1024 idle clocks: PWM low, PERIOD_END exactly at count 255.
    highs = 0;
    for (int i = 0; i < 1024; i++) begin
      tick();
      highs += int'(a_pwm_out);
      check("idle_period_end", a_period_end, (m_cnt == 8'd255));
    end
    check("idle_pwm_highs", highs, 0);
    check("idle_duty", a_duty, 0);
    check("idle_ready", a_tgt_ready, 1);

    // Ramp up 0 -> 64 on instance a.
    a_tgt_duty = 8'd64; a_tgt_valid = 1'b1;
    tick();
    a_tgt_valid = 1'b0;
    check("up_busy", a_busy, 1);
    check("up_ready", a_tgt_ready, 0);
    check("up_duty0", a_duty, 0);
    next_boundary(); check("up_duty16", a_duty, 16);
    next_boundary(); check("up_duty32", a_duty, 32);
    next_boundary(); check("up_duty48", a_duty, 48);
    next_boundary(); check("up_duty64", a_duty, 64);
    check("up_done_busy", a_busy, 0);
    check("up_done_ready", a_tgt_ready, 1);
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      highs += int'(a_pwm_out);
      tick();
    end
    check("up_pwm_highs", highs, 64);

    // Ramp down 64 -> 10 with clamp on the last step.
    a_tgt_duty = 8'd10; a_tgt_valid = 1'b1;
    tick();
    a_tgt_valid = 1'b0;
    check("dn_busy", a_busy, 1);
    next_boundary(); check("dn_duty48", a_duty, 48);
    next_boundary(); check("dn_duty32", a_duty, 32);
    next_boundary(); check("dn_duty16", a_duty, 16);
    next_boundary(); check("dn_duty10", a_duty, 10);
    check("dn_done_busy", a_busy, 0);

    // Handshake: TGT_VALID held through a ramp 10 -> 40 with a new value of 100.
    a_tgt_duty = 8'd40; a_tgt_valid = 1'b1;
    tick();
    a_tgt_duty = 8'd100;
    next_boundary();
    check("hs_duty26", a_duty, 26);
    check("hs_ready_low", a_tgt_ready, 0);
    next_boundary();
    check("hs_duty40", a_duty, 40);
    check("hs_ready_high", a_tgt_ready, 1);
    tick();
    a_tgt_valid = 1'b0;
    check("hs_accept_busy", a_busy, 1);
    check("hs_accept_duty", a_duty, 40);
    next_boundary(); check("hs_duty56", a_duty, 56);
    next_boundary(); check("hs_duty72", a_duty, 72);
    next_boundary(); check("hs_duty88", a_duty, 88);
    next_boundary(); check("hs_duty100", a_duty, 100);
    check("hs_done_busy", a_busy, 0);

    // Equal target: stays idle.
    a_tgt_duty = 8'd100; a_tgt_valid = 1'b1;
    busy_seen = 1'b0;
    tick();
    a_tgt_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      busy_seen |= a_busy;
      tick();
    end
    check("eq_busy_never", busy_seen, 0);
    check("eq_duty", a_duty, 100);
    check("eq_ready", a_tgt_ready, 1);

    // RAMP_DIV=3 on instance b, accept landing on a PERIOD_END edge.
    while (m_cnt != 8'd255) tick();
    check("div_pe_at_accept", b_period_end, 1);
    b_tgt_duty = 8'd32; b_tgt_valid = 1'b1;
    tick();
    b_tgt_valid = 1'b0;
    check("div_accept_nostep", b_duty, 0);
    check("div_accept_busy", b_busy, 1);
    next_boundary(); check("div_b1", b_duty, 0);
    next_boundary(); check("div_b2", b_duty, 0);
    next_boundary(); check("div_b3", b_duty, 16);
    next_boundary(); check("div_b4", b_duty, 16);
    next_boundary(); check("div_b5", b_duty, 16);
    next_boundary(); check("div_b6", b_duty, 32);
    check("div_done_busy", b_busy, 0);

    // Reset mid-ramp: a at 32 heading for 128.
    RST = 1'b1;
    tick();
    m_cnt = '0;
    RST = 1'b0;
    a_tgt_duty = 8'd128; a_tgt_valid = 1'b1;
    tick();
    a_tgt_valid = 1'b0;
    next_boundary(); check("mr_duty16", a_duty, 16);
    next_boundary(); check("mr_duty32", a_duty, 32);
    for (int i = 0; i < 5; i++) tick();
    RST = 1'b1;
    tick();
    m_cnt = '0;
    RST = 1'b0;
    check("mr_duty", a_duty, 0);
    check("mr_busy", a_busy, 0);
    check("mr_pwm", a_pwm_out, 0);
    check("mr_ready", a_tgt_ready, 1);
    check("mr_period_end", a_period_end, 0);
    while (m_cnt != 8'd255) tick();
    check("mr_cnt_restart", a_period_end, 1);
    next_boundary();
    next_boundary();
    check("mr_no_step", a_duty, 0);
    check("mr_still_idle", a_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
